spw_rx_credit_fifo: RTL

Parametrised receive buffer for the SpaceWire ultra-light link. It is the successor of the fixed-depth RX FIFO. It stores received N-chars (9-bit: flag + data) and owns flow-control credit accounting. It raises a request/acknowledge FCT handshake toward the transmitter whenever enough uncommitted space exists. It also flags credit and overflow errors, and counts complete packets (EOP/EEP) held in the buffer.

---
 rtl/spw_rx_pkg.sv | 17 +
 rtl/spw_rx_credit_ctrl.sv | 61 ++++++
 rtl/spw_rx_credit_fifo.sv | 91 +++++++++
 3 files changed

// File: rtl/spw_rx_pkg.sv
// Shared definitions for the SpaceWire receive buffer: FCT grant size,
// packet-marker encodings and the credit handshake states.
package spw_rx_pkg;

  localparam int FCT_CHUNK_DEF = 8;

  localparam logic [8:0] NCHAR_EOP = 9'h100;
  localparam logic [8:0] NCHAR_EEP = 9'h101;

  typedef enum logic {IDLE, REQ} credit_state_t;

  // Any control char with data[1]==0 closes a packet (EOP or EEP).
  function automatic logic is_eop_eep(input logic [8:0] nchar);
    return (nchar & 9'h102) == (NCHAR_EOP & 9'h102);
  endfunction

endpackage

// File: rtl/spw_rx_credit_ctrl.sv
// Credit accounting: tracks outstanding link credit and raises one FCT
// request whenever a full chunk of uncommitted space is available.
module spw_rx_credit_ctrl
  import spw_rx_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int FCT_CHUNK  = FCT_CHUNK_DEF,
  parameter int MAX_CREDIT = 56,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [CNT_W-1:0] counter,
  input  logic             wr_acc,
  input  logic             fct_ack,
  output logic             fct_req,
  output logic [CNT_W-1:0] outstanding
);

  // One extra bit so DEPTH - counter - outstanding can never wrap.
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W:0]   CHUNK_X = (CNT_W + 1)'(FCT_CHUNK);
  localparam logic [CNT_W:0]   MAXC_X  = (CNT_W + 1)'(MAX_CREDIT);
  localparam logic [CNT_W-1:0] CHUNK_C = CNT_W'(FCT_CHUNK);

  credit_state_t  state, state_nxt;
  logic [CNT_W:0] free_x, grant_x;
  logic           grant_ok, ack_hit;

  always_comb begin
    free_x    = DEPTH_X - {1'b0, counter} - {1'b0, outstanding};
    grant_x   = {1'b0, outstanding} + CHUNK_X;
    grant_ok  = (free_x >= CHUNK_X) && (grant_x <= MAXC_X);
    state_nxt = state;
    fct_req   = 1'b0;
    ack_hit   = 1'b0;
    case (state)
      IDLE: if (grant_ok) state_nxt = REQ;
      REQ: begin
        fct_req = 1'b1;
        if (fct_ack) begin
          ack_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state       <= IDLE;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding - CNT_W'(wr_acc) + (ack_hit ? CHUNK_C : '0);
    end
  end

endmodule

// File: rtl/spw_rx_credit_fifo.sv
// SpaceWire receive buffer: N-char storage with registered reads, credit
// handshake toward the transmitter, sticky errors and a stored-packet count.
module spw_rx_credit_fifo
  import spw_rx_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int DEPTH      = 64,
  parameter int FCT_CHUNK  = FCT_CHUNK_DEF,
  parameter int MAX_CREDIT = 56,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              f_full,
  output logic              f_empty,
  output logic [CNT_W-1:0]  counter,
  output logic              fct_req,
  input  logic              fct_ack,
  output logic              credit_error,
  output logic              overflow_error,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  outstanding;
  logic [DATA_W-1:0] rd_word;
  logic              wr_acc, rd_acc, pkt_inc, pkt_dec;

  assign f_full  = counter == CNT_W'(DEPTH);
  assign f_empty = counter == '0;
  assign wr_acc  = wr_en && (outstanding != '0) && !f_full;
  assign rd_acc  = rd_en && !f_empty;
  assign rd_word = mem[rd_ptr];
  assign pkt_inc = wr_acc && is_eop_eep({data_in[DATA_W-1], data_in[7:0]});
  assign pkt_dec = rd_acc && is_eop_eep({rd_word[DATA_W-1], rd_word[7:0]});

  spw_rx_credit_ctrl #(
    .DEPTH      (DEPTH),
    .FCT_CHUNK  (FCT_CHUNK),
    .MAX_CREDIT (MAX_CREDIT),
    .CNT_W      (CNT_W)
  ) u_credit (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .counter     (counter),
    .wr_acc      (wr_acc),
    .fct_ack     (fct_ack),
    .fct_req     (fct_req),
    .outstanding (outstanding)
  );

  // Storage is never cleared; pointers and counter alone define contents.
  always_ff @(posedge clock) begin
    if (wr_acc && !reset && !flush) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      counter        <= '0;
      pkt_count      <= '0;
      data_out       <= '0;
      rd_valid       <= 1'b0;
      credit_error   <= 1'b0;
      overflow_error <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= rd_word;
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      counter   <= counter + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      pkt_count <= pkt_count + CNT_W'(pkt_inc) - CNT_W'(pkt_dec);
      if (wr_en && outstanding == '0) credit_error   <= 1'b1;
      if (wr_en && f_full)            overflow_error <= 1'b1;
    end
  end

endmodule
